// File: rtl/mmr_register_scrubber.sv
`timescale 1ns/1ps
// K-way redundant register store that feeds the majority voter and scrubs every
// copy back to the voted value, either periodically or on request, when the voter flags a mismatch.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | copies held; period counter running; waiting for a scrub trigger
//   SETTLE | copies stable; waiting for voted_i/mismatch_i to reflect them
//   CHECK  | single cycle; rewrites all copies from voted_i when mismatch_i is set
module mmr_register_scrubber #(
  parameter int unsigned  K_MMR        = 3,
  parameter int unsigned  N            = 16,
  parameter logic [N-1:0] RESET_VALUE  = '0,
  parameter int unsigned  SCRUB_PERIOD = 1024,
  parameter int unsigned  VOTE_LATENCY = 1,
  parameter int unsigned  CNT_W        = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [N-1:0]            wr_data_i,
  input  logic                    scrub_req_i,
  input  logic                    cnt_clear_i,
  input  logic [N-1:0]            voted_i,
  input  logic                    mismatch_i,
  input  logic                    mismatch_2nd_i,
  output logic [K_MMR-1:0][N-1:0] copies_o,
  output logic                    scrub_busy_o,
  output logic                    corrected_o,
  output logic [CNT_W-1:0]        corr_cnt_o,
  output logic [CNT_W-1:0]        mm2_cnt_o
);

  localparam int unsigned PER_W = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
  localparam int unsigned SET_W = (VOTE_LATENCY > 1) ? $clog2(VOTE_LATENCY + 1) : 1;

  localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(SCRUB_PERIOD - 1);
  localparam logic [PER_W-1:0] PER_ONE    = PER_W'(1);
  localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(VOTE_LATENCY);
  localparam logic [SET_W-1:0] SET_ONE    = SET_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [K_MMR-1:0][N-1:0]  r_copies;
  logic [PER_W-1:0]         r_period;
  logic [SET_W-1:0]         r_settle;
  logic                     r_busy;
  logic                     r_corrected;
  logic [CNT_W-1:0]         r_corr_cnt;
  logic [CNT_W-1:0]         r_mm2_cnt;
  logic                     r_mm2_q;

  logic                     w_period_tc;
  logic                     w_corr_evt;
  logic                     w_mm2_rise;

  assign w_period_tc = (r_period == '0);
  assign w_corr_evt  = (r_state == ST_CHECK) && mismatch_i && !wr_en_i;
  assign w_mm2_rise  = mismatch_2nd_i && !r_mm2_q;

  // A write always wins: it reloads every copy and abandons any scrub in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_copies    <= {K_MMR{RESET_VALUE}};
      r_period    <= PER_RELOAD;
      r_settle    <= '0;
      r_busy      <= 1'b0;
      r_corrected <= 1'b0;
    end else begin
      r_corrected <= 1'b0;
      if (wr_en_i) begin
        r_copies <= {K_MMR{wr_data_i}};
        r_period <= PER_RELOAD;
        r_state  <= ST_IDLE;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_period <= w_period_tc ? PER_RELOAD : (r_period - PER_ONE);
            if (w_period_tc || scrub_req_i) begin
              r_state  <= ST_SETTLE;
              r_busy   <= 1'b1;
              r_settle <= SET_RELOAD;
            end
          end
          ST_SETTLE: begin
            if (r_settle == '0) begin
              r_state <= ST_CHECK;
            end else begin
              r_settle <= r_settle - SET_ONE;
            end
          end
          ST_CHECK: begin
            if (mismatch_i) begin
              r_copies    <= {K_MMR{voted_i}};
              r_corrected <= 1'b1;
            end
            r_period <= PER_RELOAD;
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Clear beats a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_corr_cnt <= '0;
      r_mm2_cnt  <= '0;
      r_mm2_q    <= 1'b0;
    end else begin
      r_mm2_q <= mismatch_2nd_i;
      if (cnt_clear_i) begin
        r_corr_cnt <= '0;
        r_mm2_cnt  <= '0;
      end else begin
        if (w_corr_evt && (r_corr_cnt != CNT_MAX)) begin
          r_corr_cnt <= r_corr_cnt + CNT_ONE;
        end
        if (w_mm2_rise && (r_mm2_cnt != CNT_MAX)) begin
          r_mm2_cnt <= r_mm2_cnt + CNT_ONE;
        end
      end
    end
  end

  assign copies_o     = r_copies;
  assign scrub_busy_o = r_busy;
  assign corrected_o  = r_corrected;
  assign corr_cnt_o   = r_corr_cnt;
  assign mm2_cnt_o    = r_mm2_cnt;

endmodule

// File: doc/mmr_register_scrubber.md
Name: mmr_register_scrubber

Overview:
- Upstream storage stage for the K-modular-redundant voter array.
- Holds K_MMR copies of an N-bit register and drives them into the voter.
- Takes the voted value and mismatch flags back from the voter, and periodically (or on request) scrubs all copies to the voted value when a mismatch is present.
- Keeps saturating counters of corrections and secondary-mismatch events for slow-control readout.

Parameters:
- K_MMR, 3, number of redundant copies; must be odd and ≥3.
- N, 16, width of each copy.
- RESET_VALUE, 0, value loaded into every copy at reset (N bits).
- SCRUB_PERIOD, 1024, cycles between automatic scrubs; ≥ VOTE_LATENCY+2.
- VOTE_LATENCY, 1, cycles from copies_o change to valid voted_i/mismatch_i; 0 or 1 (1 matches a registered-mismatch voter).
- CNT_W, 16, width of the event counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-high.
- wr_en_i  in  1  single-cycle write strobe.
- wr_data_i  in  N  write data; loaded into all copies.
- scrub_req_i  in  1  pulse; requests an immediate scrub.
- cnt_clear_i  in  1  synchronous clear of both counters.
- voted_i  in  N  voted value from the voter.
- mismatch_i  in  1  primary mismatch from the voter.
- mismatch_2nd_i  in  1  secondary mismatch from the voter.
- copies_o  out  [K_MMR][N]  the K stored copies, to the voter input.
- scrub_busy_o  out  1  high while the FSM is not in IDLE.
- corrected_o  out  1  one-cycle pulse when a scrub rewrote the copies.
- corr_cnt_o  out  CNT_W  number of corrections performed, saturating.
- mm2_cnt_o  out  CNT_W  rising edges of mismatch_2nd_i, saturating.

Behaviour:
- Reset values (asynchronous):
  - every copy = RESET_VALUE
  - FSM = IDLE
  - period counter = SCRUB_PERIOD-1
  - all outputs 0, except copies_o
  - mismatch_2nd_i edge register = 0
- Write:
  - wr_en_i high: all K copies <= wr_data_i on the next edge; copies_o shows it 1 cycle later.
  - Always accepted; no backpressure.
- Period counter:
  - Decrements each cycle in IDLE.
  - At 0 it raises an internal scrub trigger and reloads to SCRUB_PERIOD-1.
  - Any write also reloads it.
- FSM states: IDLE, SETTLE, CHECK.
  - IDLE -> SETTLE on scrub trigger or scrub_req_i, when wr_en_i is low.
  - SETTLE:
    - Waits VOTE_LATENCY cycles using a small counter.
    - With VOTE_LATENCY=0 it lasts exactly 1 cycle.
    - Then -> CHECK.
  - CHECK, lasts 1 cycle:
    - If mismatch_i=1: all copies <= voted_i, corrected_o pulses, corr_cnt_o increments.
    - Then -> IDLE, and the period counter reloads.
  - wr_en_i in SETTLE or CHECK:
    - The write wins and the scrub is aborted -> IDLE.
    - No correction and no count.
  - scrub_req_i while busy is ignored; it is not queued.
- Counters:
  - Saturate at 2^CNT_W-1.
  - cnt_clear_i takes priority over a simultaneous increment; the result is 0.
  - mm2_cnt_o counts 0->1 transitions of mismatch_2nd_i sampled on clk_i, in any state.
- Scrub latency: from scrub_req_i to the corrected copies on copies_o is VOTE_LATENCY+3 cycles (1 cycle to enter SETTLE counted).
- Reset mid-scrub: immediate return to reset values; no partial write.
- Copies outside a write or a scrub CHECK are never modified by this block. Upsets are modelled by the bench forcing the copy registers.

Test Plan:
1. Reset with RESET_VALUE=16'hA5A5 -> all 3 copies = A5A5, scrub_busy_o=0, both counters 0.
2. wr_en_i with wr_data_i=16'h1234 -> all copies = 1234 next cycle; period counter reloaded; no corrected_o pulse.
3. Force copy[1]=16'h1235 with voter model (voted_i=1234, mismatch_i=1), then pulse scrub_req_i -> after VOTE_LATENCY+3 cycles all copies = 1234, corrected_o pulses once, corr_cnt_o=1.
4. SCRUB_PERIOD=8, no mismatch -> scrub_busy_o asserts every 8 idle cycles plus the scrub duration; copies unchanged; corr_cnt_o stays 0.
5. scrub_req_i, then wr_en_i (data 16'h00FF) during SETTLE while mismatch_i=1 -> copies = 00FF, no correction, corr_cnt_o unchanged, FSM back in IDLE.
6. CNT_W=2:
   - Toggle mismatch_2nd_i 5 times -> mm2_cnt_o saturates at 3.
   - Assert cnt_clear_i on the same cycle as a rising edge -> mm2_cnt_o=0.
